// File: rtl/debounced_load_register.sv
// debounced_load_register
// A bouncing pushbutton is synchronised and then debounced. Each accepted
// press updates the register q once, using the operation selected by mode.
// Build option: define DLR_SHIFT_EN to enable mode decoding (load, shift
// left, shift right, rotate left). Without it every accepted press loads d.
//
// Output handshake: stb is a pure one-cycle strobe with no ready/back-pressure.
// It is high in the cycle after the edge that updated q, once per accepted
// press. busy is high whenever the FSM is not in IDLE.
module debounced_load_register #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             stb,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             stb_q;
  logic             sync1_q;
  logic             sync2_q;
  logic             btn_s;

  // Two-flop synchroniser; the FSM only ever looks at btn_s.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  assign btn_s = sync2_q;

`ifdef DLR_SHIFT_EN
  // Value q takes on an update edge, selected by mode on that same edge.
  always_comb begin
    q_d = d;
    case (mode)
      2'b00:   q_d = d;
      2'b01:   q_d = {q_q[WIDTH-2:0], d[0]};
      2'b10:   q_d = {d[0], q_q[WIDTH-1:1]};
      default: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
    endcase
  end
`else
  logic unused_mode;
  assign unused_mode = ^mode;

  // Value q takes on an update edge: always a plain load of d.
  always_comb begin
    q_d = d;
  end
`endif

  // Debounce FSM: press and release each need DEBOUNCE_CYCLES stable
  // samples; the register update happens on the edge that confirms a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      stb_q   <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_q <= DEB_PRESS;
            cnt_q   <= CNT_ONE;
          end
        end
        DEB_PRESS: begin
          if (!btn_s) begin
            // Bounce: abandon the press without touching q.
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            q_q     <= q_d;
            stb_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        PRESSED: begin
          // Held button: stay here, no further updates.
          if (!btn_s) begin
            state_q <= DEB_RELEASE;
            cnt_q   <= CNT_ONE;
          end
        end
        DEB_RELEASE: begin
          if (btn_s) begin
            // Release glitch: still pressed, no new update.
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign q           = q_q;
  assign stb         = stb_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_debounced_load_register.sv
// Bench for debounced_load_register (WIDTH=4, DEBOUNCE_CYCLES=4).
// A run-length model of the debounce rules predicts q/stb/busy every cycle;
// hand-computed values queued per press pin the model and count stb pulses.
module tb_debounced_load_register;

  localparam int W  = 4;
  localparam int DC = 4;

  // ---------------- clock / reset / DUT ----------------
  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic         btn  = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] d    = '0;
  logic [W-1:0] q;
  logic         stb;
  logic         busy;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  debounced_load_register #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .mode       (mode),
    .d          (d),
    .q          (q),
    .stb        (stb),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // btn_s is btn delayed by two samples. Outside a press, a run of DC
  // consecutive high btn_s samples accepts the press; inside a press, a run
  // of DC consecutive low samples ends it. Any opposite sample resets the run.
  logic         m_h1 = 1'b0;
  logic         m_h2 = 1'b0;
  bit           m_pressed = 1'b0;
  int           m_run = 0;
  logic [W-1:0] m_q = '0;
  logic         m_stb = 1'b0;

  function automatic logic [W-1:0] apply_op(input logic [1:0] md, input logic [W-1:0] cur,
                                            input logic [W-1:0] din);
`ifdef DLR_SHIFT_EN
    case (md)
      2'd0:    return din;
      2'd1:    return (cur << 1) | W'(din[0]);
      2'd2:    return (cur >> 1) | (W'(din[0]) << (W - 1));
      default: return (cur << 1) | (cur >> (W - 1));
    endcase
`else
    return din;
`endif
  endfunction

  always @(posedge clk) begin : model
    logic bs;
    if (rst) begin
      m_h1 = 1'b0; m_h2 = 1'b0; m_pressed = 1'b0; m_run = 0; m_q = '0; m_stb = 1'b0;
    end else begin
      bs = m_h2;
      m_h2 = m_h1;
      m_h1 = btn;
      m_stb = 1'b0;
      if (!m_pressed) begin
        if (bs) begin
          m_run++;
          if (m_run == DC) begin
            m_pressed = 1'b1;
            m_run = 0;
            m_q = apply_op(mode, m_q, d);
            m_stb = 1'b1;
          end
        end else m_run = 0;
      end else begin
        if (!bs) begin
          m_run++;
          if (m_run == DC) begin
            m_pressed = 1'b0;
            m_run = 0;
          end
        end else m_run = 0;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("q_model", q, m_q);
    check("stb_model", stb, m_stb);
    check("busy_model", busy, (m_pressed || m_run != 0));
    if (stb === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stb_unexpected: got stb=1 q=%0h expected no pulse at %0t", q, $time);
      end else begin
        check("q_on_stb", q, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs always change 1 time unit after a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] md, input logic [W-1:0] dv, input int hold,
                       input logic [W-1:0] expv);
    exp_q.push_back(expv);
    mode = md;
    d    = dv;
    btn  = 1'b1;
    tick(hold);
    btn = 1'b0;
    tick(DC + 6);
    check("busy_after_release", busy, 1'b0);
    check("q_after_press", q, expv);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    tick(3);
    check("reset_q", q, 4'b0000);
    check("reset_stb", stb, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_state", dbg_state, 2'd0);
    rst = 1'b0;
    tick(1);

    // Clean press: update exactly on edge 6
    exp_q.push_back(4'b1010);
    mode = 2'b00;
    d    = 4'b1010;
    btn  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      check("clean_q_before_edge6", q, 4'b0000);
    end
    tick(1);
    check("clean_q_edge6", q, 4'b1010);
    check("clean_stb_edge6", stb, 1'b1);
    tick(1);
    check("clean_stb_one_cycle", stb, 1'b0);
    tick(5);
    btn = 1'b0;
    tick(DC + 6);
    check("clean_busy_released", busy, 1'b0);

    // Bounce: high 2, low 1, then held
    exp_q.push_back(4'b0111);
    d   = 4'b0111;
    btn = 1'b1;
    tick(2);
    btn = 1'b0;
    tick(1);
    btn = 1'b1;
    tick(10);
    btn = 1'b0;
    tick(DC + 6);
    check("bounce_q", q, 4'b0111);
    check("bounce_busy", busy, 1'b0);

    // Mode operations
    press(2'b00, 4'b1001, 10, 4'b1001);
`ifdef DLR_SHIFT_EN
    press(2'b01, 4'b0001, 10, 4'b0011);
    press(2'b10, 4'b0000, 10, 4'b0001);
    press(2'b11, 4'b0000, 10, 4'b0010);
`else
    press(2'b01, 4'b0001, 10, 4'b0001);
    press(2'b10, 4'b0000, 10, 4'b0000);
    press(2'b11, 4'b0000, 10, 4'b0000);
`endif

    // Long hold with mode=11, inputs changed after the update, release glitch
`ifdef DLR_SHIFT_EN
    exp_q.push_back(4'b0100);
`else
    exp_q.push_back(4'b1100);
`endif
    mode = 2'b11;
    d    = 4'b1100;
    btn  = 1'b1;
    tick(20);
    mode = 2'b00;
    d    = 4'b1111;
    tick(30);
    btn = 1'b0;
    tick(2);
    btn = 1'b1;
    tick(1);
    btn = 1'b0;
    tick(DC + 8);
`ifdef DLR_SHIFT_EN
    check("hold_q", q, 4'b0100);
`else
    check("hold_q", q, 4'b1100);
`endif
    check("hold_busy", busy, 1'b0);

    // Reset mid-debounce, button still held afterwards
    mode = 2'b00;
    d    = 4'b1111;
    btn  = 1'b1;
    tick(3);
    rst = 1'b1;
    #1;
    check("midrst_q_immediate", q, 4'b0000);
    check("midrst_busy_immediate", busy, 1'b0);
    check("midrst_stb_immediate", stb, 1'b0);
    tick(1);
    rst = 1'b0;
    exp_q.push_back(4'b1111);
    tick(5);
    check("postrst_q_edge5", q, 4'b0000);
    tick(1);
    check("postrst_q_edge6", q, 4'b1111);
    check("postrst_stb_edge6", stb, 1'b1);
    btn = 1'b0;
    tick(DC + 6);

    // mode=01 with d=0101: load without shift support
`ifdef DLR_SHIFT_EN
    press(2'b01, 4'b0101, 10, 4'b1111);
`else
    press(2'b01, 4'b0101, 10, 4'b0101);
`endif

    tick(2);
    check("all_pulses_seen", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
